data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Bridge between the mips core data port and the data_ram block RAM (32-bit data, 16-bit word address, 4-bit byte write enable, synchronous read). It accepts one byte, halfword or word load/store at a time and stalls the core until the access retires. It generates the RAM enable, byte write strobes and replicated store data, and waits out the RAM read latency. It extracts, sign-extends or zero-extends load data and flags misaligned accesses.

Parameters:
ADDR_W, 16, RAM word-address width; byte address bits [ADDR_W+1:2] index RAM, higher bits ignored (wrap)
READ_LAT, 1, RAM clock cycles from enable edge to valid douta (legal 1..3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  access request; held stable by core while cpu_stall=1
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
cpu_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-justified
cpu_stall  out  1  core must hold request/pipeline
cpu_rdata  out  32  extended load result, valid when cpu_rvalid=1
cpu_rvalid  out  1  one-cycle load-complete pulse
cpu_err  out  1  one-cycle misaligned/illegal pulse
ram_ena  out  1  RAM enable (registered)
ram_wea  out  4  RAM byte write enables (registered)
ram_addr  out  ADDR_W  RAM word address (registered)
ram_dina  out  32  RAM write data (registered)
ram_douta  in  32  RAM read data

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; wait counter 0; ram_ena drops immediately, including mid-access. Aborted access is lost; the core is reset alongside.
- States: IDLE, WRITE, READ, WAIT, DONE, ERR.
- cpu_stall = (state==IDLE && cpu_req) || state==READ || state==WAIT. It is combinational and 0 in WRITE, DONE and ERR, the retire cycle.
- IDLE, cpu_req=0: stay; ram_ena=0, ram_wea=0.
- IDLE, cpu_req=1, misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=11): go to ERR; no RAM access.
- IDLE, cpu_req=1, aligned store: register ram_addr=addr[ADDR_W+1:2], ram_ena=1, ram_wea and ram_dina; go to WRITE.
- IDLE, cpu_req=1, aligned load: register ram_addr, ram_ena=1, ram_wea=0, and latch size/unsigned/addr[1:0]; go to READ.
- WRITE: RAM samples on the exiting edge; ram_ena/ram_wea clear; go to IDLE. A store occupies 2 cycles, with 1 stall cycle.
- READ: ram_ena clears; counter loads READ_LAT; go to WAIT.
- WAIT: counter decrements each cycle. When counter==1, capture the extracted ram_douta into cpu_rdata and go to DONE.
- DONE: cpu_rvalid=1 for one cycle; go to IDLE. cpu_rdata holds its value until the next load completes.
- ERR: cpu_err=1 for one cycle; go to IDLE. cpu_rdata is unchanged.
- Load latency, request to retire: 3+READ_LAT cycles (4 at default), with 2+READ_LAT stall cycles.
- A new request is accepted only in IDLE, so back-to-back accesses insert one IDLE cycle.
- cpu_req outside IDLE is ignored (the held request).
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]==k.
- Store byte: dina={4{wdata[7:0]}}, wea=4'b0001<<addr[1:0].
- Store half: dina={2{wdata[15:0]}}, wea = addr[1] ? 4'b1100 : 4'b0011.
- Store word: dina=wdata, wea=4'b1111.
- Load byte: lane addr[1:0], extended to 32 bits per unsigned.
- Load half: bits [31:16] if addr[1]=1, else [15:0], extended.
- Load word: douta unmodified; unsigned is ignored.
- cpu_rvalid and cpu_err are never both 1. ram_ena is never 1 outside the cycle after acceptance.

Test Plan:
- Reset check: hold rst=0 with random inputs → all outputs 0. Release rst, cpu_req=0 for 5 cycles → ram_ena never 1.
- Store word: sw 0xDEADBEEF to 0x0000_0010 → one cycle with ram_ena=1, wea=1111, addr=0x0004, dina=0xDEADBEEF; cpu_stall high exactly 1 cycle.
- Store byte, then loads: sb 0x000000A5 to 0x13 → wea=1000, dina=0xA5A5A5A5. Then lb 0x13 → cpu_rdata=0xFFFFFFA5, rvalid pulse, stall=3 cycles. Then lbu 0x13 → 0x000000A5.
- Load half, both halves: with RAM word 4 = 0x8001_7FFE, lh 0x12 → 0xFFFF8001; lhu 0x10 → 0x00007FFE.
- Misaligned: lh 0x11 and sw 0x02 → cpu_err pulse 1 cycle each, ram_ena stays 0, cpu_rdata unchanged.
- Latency and reset abort: with READ_LAT=2, lw → stall 4 cycles, rvalid in cycle 5. Then assert rst during WAIT → outputs 0 immediately; after release, lw retires normally with correct data.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding load/store bridge between the core data
// port and a synchronous-read block RAM. Stalls the core until each access
// retires, drives registered RAM controls, and extends load data.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for cpu_req; accepts and launches a new access
// WRITE | RAM enable/strobes presented; store commits on exiting edge
// READ  | RAM enable presented for the load; latency counter armed next
// WAIT  | counting down RAM read latency; capture data at count 1
// DONE  | load retire cycle, cpu_rvalid pulse
// ERR   | misaligned/illegal retire cycle, cpu_err pulse
module data_mem_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_err,
  output logic              ram_ena,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 2;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ld_size;
  logic             ld_uns;
  logic [1:0]       ld_off;

  logic             misaligned;
  logic [3:0]       st_wea;
  logic [31:0]      st_dina;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;

  // Byte address bits above the RAM window wrap and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu_addr[31:ADDR_W+2];

  // Core handshake and retire pulses; stall is forced low while in reset so
  // every output reads 0 regardless of what the core is driving.
  always_comb begin
    cpu_stall  = rst & (((state == IDLE) && cpu_req) || (state == READ) || (state == WAIT));
    cpu_rvalid = (state == DONE);
    cpu_err    = (state == ERR);
  end

  // Alignment check for the request presented in IDLE.
  always_comb begin
    misaligned = 1'b0;
    case (cpu_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = cpu_addr[0];
      SZ_WORD: misaligned = (cpu_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Store lane replication and byte strobes, little-endian lanes.
  always_comb begin
    st_wea  = 4'b1111;
    st_dina = cpu_wdata;
    case (cpu_size)
      SZ_BYTE: begin
        st_wea  = 4'b0001 << cpu_addr[1:0];
        st_dina = {4{cpu_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_wea  = cpu_addr[1] ? 4'b1100 : 4'b0011;
        st_dina = {2{cpu_wdata[15:0]}};
      end
      default: begin
        st_wea  = 4'b1111;
        st_dina = cpu_wdata;
      end
    endcase
  end

  // Load lane select and sign/zero extension using the latched access shape.
  always_comb begin
    ld_byte = ram_douta[7:0];
    case (ld_off)
      2'd0:    ld_byte = ram_douta[7:0];
      2'd1:    ld_byte = ram_douta[15:8];
      2'd2:    ld_byte = ram_douta[23:16];
      default: ld_byte = ram_douta[31:24];
    endcase
    ld_half = ld_off[1] ? ram_douta[31:16] : ram_douta[15:0];
    case (ld_size)
      SZ_BYTE: ld_ext = {{24{ld_byte[7] & ~ld_uns}}, ld_byte};
      SZ_HALF: ld_ext = {{16{ld_half[15] & ~ld_uns}}, ld_half};
      default: ld_ext = ram_douta;
    endcase
  end

  // Access sequencer: launches RAM cycles, times the read latency, retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ld_size   <= '0;
      ld_uns    <= 1'b0;
      ld_off    <= '0;
      cpu_rdata <= '0;
      ram_ena   <= 1'b0;
      ram_wea   <= '0;
      ram_addr  <= '0;
      ram_dina  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (misaligned) begin
              state <= ERR;
            end else begin
              ram_ena  <= 1'b1;
              ram_addr <= cpu_addr[ADDR_W+1:2];
              if (cpu_we) begin
                ram_wea  <= st_wea;
                ram_dina <= st_dina;
                state    <= WRITE;
              end else begin
                ram_wea <= 4'b0000;
                ld_size <= cpu_size;
                ld_uns  <= cpu_unsigned;
                ld_off  <= cpu_addr[1:0];
                state   <= READ;
              end
            end
          end
        end
        WRITE: begin
          ram_ena <= 1'b0;
          ram_wea <= 4'b0000;
          state   <= IDLE;
        end
        READ: begin
          ram_ena <= 1'b0;
          cnt     <= CNT_W'(READ_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            cpu_rdata <= ld_ext;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: dut_a at default latency, dut_b at READ_LAT=2,
// each with its own behavioural block RAM.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0, wdata = '0;

  logic        stall_a, rvalid_a, err_a, ena_a;
  logic [31:0] rdata_a, dina_a, douta_a;
  logic [3:0]  wea_a;
  logic [15:0] raddr_a;
  logic        stall_b, rvalid_b, err_b, ena_b;
  logic [31:0] rdata_b, dina_b, douta_b;
  logic [3:0]  wea_b;
  logic [15:0] raddr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(16), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .cpu_req(req_a), .cpu_we(we), .cpu_size(size),
    .cpu_unsigned(uns), .cpu_addr(addr), .cpu_wdata(wdata),
    .cpu_stall(stall_a), .cpu_rdata(rdata_a), .cpu_rvalid(rvalid_a), .cpu_err(err_a),
    .ram_ena(ena_a), .ram_wea(wea_a), .ram_addr(raddr_a), .ram_dina(dina_a),
    .ram_douta(douta_a));

  data_mem_ctrl #(.ADDR_W(16), .READ_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .cpu_req(req_b), .cpu_we(we), .cpu_size(size),
    .cpu_unsigned(uns), .cpu_addr(addr), .cpu_wdata(wdata),
    .cpu_stall(stall_b), .cpu_rdata(rdata_b), .cpu_rvalid(rvalid_b), .cpu_err(err_b),
    .ram_ena(ena_b), .ram_wea(wea_b), .ram_addr(raddr_b), .ram_dina(dina_b),
    .ram_douta(douta_b));

  // Behavioural RAMs: read-first, output register(s) only update on enable.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] pa0, pb0, pb1;
  assign douta_a = pa0;
  assign douta_b = pb1;

  always @(posedge clk) begin
    if (ena_a) begin
      for (int k = 0; k < 4; k++)
        if (wea_a[k]) mem_a[raddr_a[7:0]][8*k +: 8] <= dina_a[8*k +: 8];
      pa0 <= mem_a[raddr_a[7:0]];
    end
    if (ena_b) begin
      for (int k = 0; k < 4; k++)
        if (wea_b[k]) mem_b[raddr_b[7:0]][8*k +: 8] <= dina_b[8*k +: 8];
      pb0 <= mem_b[raddr_b[7:0]];
    end
    pb1 <= pb0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Per-access observations.
  int          r_stalls, r_enas, r_rv, r_er, r_rvcyc;
  logic [3:0]  r_wea;
  logic [15:0] r_addr;
  logic [31:0] r_dina, r_rdata;
  logic        r_done;

  task automatic sample(input bit sel, input int c);
    logic s, e, v, x;
    s = sel ? stall_b : stall_a;
    e = sel ? ena_b : ena_a;
    v = sel ? rvalid_b : rvalid_a;
    x = sel ? err_b : err_a;
    if (s) r_stalls++;
    if (e) begin
      r_enas++;
      r_wea  = sel ? wea_b : wea_a;
      r_addr = sel ? raddr_b : raddr_a;
      r_dina = sel ? dina_b : dina_a;
    end
    if (v) begin r_rv++; r_rvcyc = c; end
    if (x) r_er++;
  endtask

  // Present one request as the core would, hold it until stall drops,
  // then release it and observe one trailing cycle.
  task automatic access(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    int c;
    r_stalls = 0; r_enas = 0; r_rv = 0; r_er = 0; r_rvcyc = 0;
    r_wea = '0; r_addr = '0; r_dina = '0; r_rdata = '0; r_done = 1'b0;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = wd;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    c = 1;
    while (!r_done && c <= 20) begin
      #1;
      sample(sel, c);
      if (!(sel ? stall_b : stall_a)) begin
        r_done  = 1'b1;
        r_rdata = sel ? rdata_b : rdata_a;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    #1;
    sample(sel, c + 1);
    chk("retire_in_budget", {31'd0, r_done}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  wea;
    logic [31:0] dina;
    logic [15:0] raddr;
    logic [31:0] rdata;
    int          stalls;
  } vec_t;

  vec_t vt [22];

  initial begin
    logic [31:0] outs;
    string nm;

    vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF, 16'h0004, 32'h0, 1};
    vt[1]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 1'b0, 4'b1000, 32'hA5A5_A5A5, 16'h0004, 32'h0, 1};
    vt[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0004, 32'hFFFF_FFA5, 3};
    vt[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0004, 32'h0000_00A5, 3};
    vt[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0004, 32'hA5AD_BEEF, 3};
    vt[5]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8001_7FFE, 1'b0, 4'b1111, 32'h8001_7FFE, 16'h0004, 32'h0, 1};
    vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0004, 32'hFFFF_8001, 3};
    vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0004, 32'h0000_7FFE, 3};
    vt[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,         1'b1, 4'b0000, 32'h0,         16'h0000, 32'h0000_7FFE, 1};
    vt[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h1111_1111, 1'b1, 4'b0000, 32'h0,         16'h0000, 32'h0000_7FFE, 1};
    vt[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 4'b0000, 32'h0,         16'h0000, 32'h0000_7FFE, 1};
    vt[11] = '{1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h0000_0000, 1'b0, 4'b1111, 32'h0000_0000, 16'h0005, 32'h0, 1};
    vt[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234, 16'h0005, 32'h0, 1};
    vt[13] = '{1'b1, 2'b00, 1'b0, 32'h0000_0015, 32'h0000_0080, 1'b0, 4'b0010, 32'h8080_8080, 16'h0005, 32'h0, 1};
    vt[14] = '{1'b0, 2'b00, 1'b0, 32'h0000_0015, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0005, 32'hFFFF_FF80, 3};
    vt[15] = '{1'b0, 2'b01, 1'b1, 32'h0000_0016, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0005, 32'h0000_1234, 3};
    vt[16] = '{1'b0, 2'b01, 1'b0, 32'h0000_0014, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0005, 32'hFFFF_8000, 3};
    vt[17] = '{1'b0, 2'b00, 1'b1, 32'h0000_0017, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0005, 32'h0000_0012, 3};
    vt[18] = '{1'b0, 2'b10, 1'b0, 32'h0004_0010, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0004, 32'h8001_7FFE, 3};
    vt[19] = '{1'b0, 2'b10, 1'b1, 32'h0000_0014, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0005, 32'h1234_8000, 3};
    vt[20] = '{1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'hFFFF_ABCD, 1'b0, 4'b0011, 32'hABCD_ABCD, 16'h0004, 32'h0, 1};
    vt[21] = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 4'b0000, 32'h0,         16'h0004, 32'hFFFF_ABCD, 3};

    // Reset with random inputs: every output of both instances must be 0.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_a = 1'($urandom); req_b = 1'($urandom); we = 1'($urandom);
      size = 2'($urandom); uns = 1'($urandom); addr = $urandom; wdata = $urandom;
      #1;
      outs = {31'd0, stall_a | rvalid_a | err_a | ena_a | stall_b | rvalid_b | err_b | ena_b}
             | rdata_a | dina_a | rdata_b | dina_b | {12'd0, wea_a, raddr_a} | {12'd0, wea_b, raddr_b};
      chk($sformatf("reset_outs_zero_%0d", i), outs, 32'h0);
    end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle_no_ena_%0d", i), {30'd0, ena_a, ena_b}, 32'h0);
    end

    // Table-driven accesses on the default-latency instance.
    for (int i = 0; i < 22; i++) begin
      access(1'b0, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata);
      nm = $sformatf("v%0d", i);
      chk({nm, "_stall_cycles"}, r_stalls, vt[i].stalls);
      chk({nm, "_err_pulses"}, r_er, {31'd0, vt[i].err});
      if (vt[i].err) begin
        chk({nm, "_ena_cycles"}, r_enas, 0);
        chk({nm, "_rvalid_pulses"}, r_rv, 0);
        chk({nm, "_rdata_held"}, r_rdata, vt[i].rdata);
      end else begin
        chk({nm, "_ena_cycles"}, r_enas, 1);
        chk({nm, "_ram_addr"}, {16'd0, r_addr}, {16'd0, vt[i].raddr});
        chk({nm, "_ram_wea"}, {28'd0, r_wea}, {28'd0, vt[i].wea});
        if (vt[i].we) begin
          chk({nm, "_ram_dina"}, r_dina, vt[i].dina);
          chk({nm, "_rvalid_pulses"}, r_rv, 0);
        end else begin
          chk({nm, "_rvalid_pulses"}, r_rv, 1);
          chk({nm, "_rvalid_cycle"}, r_rvcyc, 4);
          chk({nm, "_rdata"}, r_rdata, vt[i].rdata);
        end
      end
    end

    // Two-cycle read latency instance.
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8001_7FFE);
    chk("lat2_sw_stall", r_stalls, 1);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    chk("lat2_lw_stall", r_stalls, 4);
    chk("lat2_lw_rvalid_cycle", r_rvcyc, 5);
    chk("lat2_lw_rvalid_pulses", r_rv, 1);
    chk("lat2_lw_rdata", r_rdata, 32'h8001_7FFE);

    // Reset abort while the load is in WAIT.
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h0000_0010; req_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_stall_in_wait", {31'd0, stall_b}, 32'd1);
    rst = 1'b0;
    #1;
    outs = {31'd0, stall_b | rvalid_b | err_b | ena_b} | rdata_b | dina_b | {12'd0, wea_b, raddr_b};
    chk("abort_outs_zero", outs, 32'h0);
    @(negedge clk);
    req_b = 1'b0;
    #1;
    chk("abort_held_zero", {31'd0, stall_b | rvalid_b | ena_b} | rdata_b, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    chk("post_abort_stall", r_stalls, 4);
    chk("post_abort_rvalid_cycle", r_rvcyc, 5);
    chk("post_abort_rdata", r_rdata, 32'h8001_7FFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
